// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// One shared add / trial-subtract per clock; DATA_W iterations plus one finishing cycle.
module mul_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    // opnd: multiplicand for multiply, divisor for divide.
    // shreg: multiplier shift register for multiply, dividend/quotient for divide.
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic              is_div;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] add_x, add_y, add_sum;
    logic              add_cin;
    logic              trial_neg;

    always_comb begin
        is_div  = op_q[1];
        rem_sh  = {rem_q[DATA_W-1:0], shreg_q[DATA_W-1]};
        add_cin = is_div;
        if (is_div) begin
            add_x = {1'b0, rem_sh};
            add_y = {2'b00, opnd_q};
        end else begin
            add_x = {2'b00, acc_q[2*DATA_W-1:DATA_W]};
            add_y = {2'b00, {DATA_W{shreg_q[0]}} & opnd_q};
        end
        // Shared adder: X + (Y ^ {Cin}) + Cin, an add or a subtract.
        add_sum   = add_x + (add_y ^ {(DATA_W+2){add_cin}}) + (DATA_W+2)'(add_cin);
        trial_neg = add_sum[DATA_W+1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    opnd_d  = i_op[1] ? i_b : i_a;
                    shreg_d = i_op[1] ? i_a : i_b;
                    acc_d   = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    case (op_q)
                        2'b00:   result_d = acc_q[DATA_W-1:0];
                        2'b01:   result_d = acc_q[2*DATA_W-1:DATA_W];
                        2'b10:   result_d = shreg_q;
                        default: result_d = rem_q[DATA_W-1:0];
                    endcase
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div) begin
                        rem_d   = trial_neg ? rem_sh : add_sum[DATA_W:0];
                        shreg_d = {shreg_q[DATA_W-2:0], ~trial_neg};
                    end else begin
                        acc_d   = {add_sum[DATA_W:0], acc_q[DATA_W-1:1]};
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            shreg_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random bench for mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    mul_div_unit #(.DATA_W(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint unsigned prod;
        prod = longint'(ma) * longint'(mb);
        case (mop)
            2'b00:   return prod[31:0];
            2'b01:   return prod[63:32];
            2'b10:   return (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
            default: return (mb == 0) ? ma : ma % mb;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for o_valid, check latency, result and busy.
    // intr > 0 pulses a conflicting start at that cycle of the operation.
    task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] ma,
                          input logic [31:0] mb, input int intr);
        logic [31:0] exp;
        int lat, busy_low, valids;
        exp = model(mop, ma, mb);
        @(negedge clk);
        start = 1'b1; op = mop; a = ma; b = mb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_low = 0; valids = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!busy) busy_low++;
            if (intr > 0 && k == intr) begin
                start = 1'b1; op = ~mop; a = ma + 32'd9; b = mb + 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                lat = k;
                valids++;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_gaps"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        chk({tag, " valid_pulse"}, {31'd0, valid}, 32'd0);
        chk({tag, " result_hold"}, result, exp);
        if (intr > 0) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (valid) valids++;
            end
            chk({tag, " single_valid"}, 32'(valids), 32'd1);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int late_valid;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        run_op("divu_msb_1", 2'b10, 32'h8000_0000, 32'd1, 0);
        run_op("remu_msb_1", 2'b11, 32'h8000_0000, 32'd1, 0);
        run_op("divu_by0", 2'b10, 32'd5, 32'd0, 0);
        run_op("remu_by0", 2'b11, 32'd5, 32'd0, 0);
        run_op("busy_start", 2'b00, 32'd3, 32'd4, 10);
        run_op("after_busy", 2'b11, 32'd50, 32'd8, 0);

        // Asynchronous reset between edges during cycle 15 of a DIVU.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid valid", {31'd0, valid}, 32'd0);
        chk("rst_mid result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        late_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) late_valid++;
        end
        chk("rst_mid no_valid", 32'(late_valid), 32'd0);
        run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = ra;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
